pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Program-counter sequencer and instruction-fetch controller for the RISC-V core. Owns the architectural PC register, issues one word-aligned fetch at a time to instruction memory over a valid/ready request channel, and hands fetched instructions with their PC to decode. Next PC is PC+4, or a redirect target (branch/jump) or trap vector from later pipeline stages.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  taken branch/jump from execute, single-cycle pulse
- redirect_target  in  32  redirect destination
- trap_valid  in  1  trap/exception, single-cycle pulse, beats redirect
- trap_vector  in  32  trap destination
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address
- imem_rsp_valid  in  1  response data valid, exactly one per accepted request
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  instruction word
- if_pc  out  32  PC of if_instr
- misalign_err  out  1  misaligned target detected (only with macro, see Configuration)

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready: pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> WAIT.
- WAIT: on imem_rsp_valid: if kill flag clear, register data+PC into if_instr/if_pc, if_valid=1, -> HOLD; if kill flag set, drop data, clear kill, -> REQ.
- HOLD: if_valid=1 until if_valid&if_ready, then -> REQ.
- Redirect/trap (new_pc = trap_vector if trap_valid else redirect_target):
  - pc <= new_pc in all states.
  - REQ with req not yet accepted: address stays stable (no retraction); kill flag set so the resulting response is discarded; pc after acceptance is new_pc, not old+4.
  - REQ accepted same cycle, or WAIT: kill flag set.
  - HOLD: if_valid dropped next cycle (flush), -> REQ.
  - Response arriving same cycle as redirect in WAIT: discarded.
- Only one request outstanding; no request issued in WAIT or HOLD.

## Timing
- Reset values: pc=RESET_VECTOR, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_VECTOR, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, kill=0, misalign_err=0.
- First imem_req_valid: second rising edge after reset_n deasserts.
- Zero-wait memory (ready=1, rsp one cycle after accept): fetch-to-if_valid = 2 cycles; steady throughput one instruction per 3 cycles with if_ready=1.
- imem_req_addr and imem_req_valid stable while valid&!ready.
- if_instr/if_pc stable while if_valid&!if_ready.
- Redirect takes effect: first request to new_pc issued no earlier than the cycle after redirect_valid.
- reset_n asserted mid-operation: immediate return to reset values; in-flight response after reset is ignored (state IDLE/REQ does not sample imem_rsp_valid).

## Configuration
- PC_FETCH_CTRL_MISALIGN_EN defined: new_pc[1:0]!=0 forces pc <= trap_vector instead, misalign_err pulses one cycle (cycle after the redirect); other redirect handling unchanged.
- Undefined: new_pc[1:0] forced to 2'b00, misalign_err port tied 0.

## Structure
- Shared package rv_pkg: XLEN=32, NOP encoding 32'h0000_0013, fetch state enum (IDLE/REQ/WAIT/HOLD), default reset vector.
- One sub-module natural: pc_reg (32-bit register, async active-low reset to RESET_VECTOR, load enable); FSM, kill flag and output register in pc_fetch_ctrl.

## Test plan
- Reset, ready=1, rsp 1 cycle later, if_ready=1, RESET_VECTOR=0 -> addrs 0x0,0x4,0x8 in order; if_pc matches; first req 2 edges after reset release.
- ready held 0 for 3 cycles at addr 0x4 -> addr/valid stable 0x4; no pc advance; accept on 4th cycle -> next addr 0x8.
- if_ready=0 for 5 cycles with if_instr=32'h00A00093 -> if_valid, if_instr, if_pc constant; no new request issued.
- redirect_valid to 0x100 in WAIT for addr 0x8 -> response for 0x8 never on if_valid; next request addr 0x100, then 0x104.
- trap_valid (vector 0x200) and redirect_valid (0x100) same cycle in HOLD -> if_valid drops, next request 0x200.
- With macro, redirect to 0x102 -> misalign_err pulse, next request trap_vector; without macro -> next request 0x100, misalign_err=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V fetch definitions: data width, NOP encoding, fetch FSM states and reset vector.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK           = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side handshake bundle: instruction-memory request/response and the decode channel.
// master = fetch controller, slave = memory + decode environment.
interface pc_fetch_ctrl_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );

endinterface

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// Architectural PC register: async active-low reset to RESET_VECTOR, loads d_i when load_en_i.
module pc_fetch_ctrl_pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load_en_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  // Hold unless a load is requested.
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) pc_d = d_i;
  end

  // PC storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_VECTOR;
    else          pc_q <= pc_d;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch controller. One fetch outstanding at a time; redirects and
// traps reload the PC and squash any in-flight or held instruction via a kill flag.
// Optional feature macro: PC_FETCH_CTRL_MISALIGN_EN (misaligned targets divert to trap_vector
// and pulse misalign_err); when undefined targets are forced word-aligned.
module pc_fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  input  logic                   trap_valid,
  input  logic [XLEN-1:0]        trap_vector,
  pc_fetch_ctrl_if.master        bus,
  output logic                   misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_load;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            redir;
  logic [XLEN-1:0] raw_pc;
  logic [XLEN-1:0] new_pc;
  logic            req_fire;
  logic            if_fire;

  // Trap wins over a simultaneous redirect.
  assign redir  = redirect_valid | trap_valid;
  assign raw_pc = trap_valid ? trap_vector : redirect_target;

  assign req_fire = (state_q == StReq) & bus.imem_req_ready;
  assign if_fire  = if_valid_q & bus.if_ready;

`ifdef PC_FETCH_CTRL_MISALIGN_EN
  logic misalign_q, misalign_d;

  assign misalign_d = redir & (raw_pc[1:0] != 2'b00);
  assign new_pc     = misalign_d ? trap_vector : raw_pc;

  // One-cycle error pulse following the offending redirect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign new_pc       = raw_pc & ALIGN_MASK;
  assign misalign_err = 1'b0;
`endif

  pc_fetch_ctrl_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_en_i(pc_load),
    .d_i      (pc_d),
    .q_o      (pc_q)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (req_fire) state_d = StWait;
      StWait: begin
        if (bus.imem_rsp_valid) state_d = (kill_q || redir) ? StReq : StHold;
      end
      StHold: if (redir || if_fire) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: request channel and decode channel.
  always_comb begin
    bus.imem_req_valid = (state_q == StReq);
    bus.imem_req_addr  = req_addr_q;
    bus.if_valid       = if_valid_q;
    bus.if_instr       = if_instr_q;
    bus.if_pc          = if_pc_q;
  end

  // PC update, kill flag, request address capture and decode output register.
  always_comb begin
    // A killed acceptance leaves the PC at the redirect target rather than advancing it.
    pc_load    = redir | (req_fire & ~kill_q);
    pc_d       = redir ? new_pc : pc_incr(pc_q);
    kill_d     = kill_q;
    req_addr_d = req_addr_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      StReq: if (redir) kill_d = 1'b1;
      StWait: begin
        // The response consumes the outstanding request, so it always clears the kill flag.
        if (bus.imem_rsp_valid) begin
          kill_d = 1'b0;
          if (!kill_q && !redir) begin
            if_valid_d = 1'b1;
            if_instr_d = bus.imem_rsp_data;
            if_pc_d    = req_addr_q;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      StHold: if (redir || if_fire) if_valid_d = 1'b0;
      default: ;
    endcase

    // Latch the fetch address only on entry to REQ so it never moves while pending.
    if (state_q != StReq && state_d == StReq) begin
      req_addr_d = pc_load ? pc_d : pc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr_q <= RESET_VECTOR;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule
